seg7_readback_decoder: RTL and testbench

//  Inverse of the hex-to-7-segment driver: samples a 7-segment bus and recovers the 4-bit value
//  it shows. Waits for the pattern to be stable, then issues one valid/ready transfer per new

---
 rtl/seg7_pkg.sv | 34 +++
 rtl/seg7_lookup.sv | 46 ++++
 rtl/seg7_readback_decoder.sv | 157 +++++++++++++++
 tb/tb_seg7_readback_decoder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Brief    : Lit-high 7-segment glyphs {g,f,e,d,c,b,a} and readback FSM states.
// Revision : 1.0
// ============================================================================
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_EMIT = 2'd1,
        S_LOCK = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seg7_lookup.sv
`default_nettype none
// ============================================================================
// Module   : seg7_lookup
// Brief    : Combinational lit-high glyph to hex nibble decoder with blank flag.
// Revision : 1.0
// ============================================================================
module seg7_lookup
    import seg7_pkg::*;
(
    input  logic [6:0] i_lit,
    output logic       o_hit,
    output logic [3:0] o_nibble,
    output logic       o_blank
);

    always_comb begin
        o_hit    = 1'b1;
        o_nibble = 4'h0;
        o_blank  = 1'b0;
        case (i_lit)
            SEG_0:     o_nibble = 4'h0;
            SEG_1:     o_nibble = 4'h1;
            SEG_2:     o_nibble = 4'h2;
            SEG_3:     o_nibble = 4'h3;
            SEG_4:     o_nibble = 4'h4;
            SEG_5:     o_nibble = 4'h5;
            SEG_6:     o_nibble = 4'h6;
            SEG_7:     o_nibble = 4'h7;
            SEG_8:     o_nibble = 4'h8;
            SEG_9:     o_nibble = 4'h9;
            SEG_A:     o_nibble = 4'hA;
            SEG_B:     o_nibble = 4'hB;
            SEG_C:     o_nibble = 4'hC;
            SEG_D:     o_nibble = 4'hD;
            SEG_E:     o_nibble = 4'hE;
            SEG_F:     o_nibble = 4'hF;
            SEG_BLANK: begin
                o_hit   = 1'b0;
                o_blank = 1'b1;
            end
            default:   o_hit = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg7_readback_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg7_readback_decoder
// Brief    : Debounces a 7-segment bus and returns the shown hex digit over valid/ready.
// Revision : 1.0
// ============================================================================
module seg7_readback_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_i,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_nibble,
    output logic       out_err,
    output logic       blank,
    output logic       overrun
);

    localparam int            CW        = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] C_CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] C_CNT_ACC = CW'(STABLE_CYCLES - 1);
    localparam logic [6:0]    C_SEG_RST = ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

    logic [6:0]    r_seg_q;
    logic [6:0]    r_seg_acc;
    logic [CW-1:0] r_count;
    state_t        r_state;
    logic          r_valid;
    logic [3:0]    r_nibble;
    logic          r_err;
    logic          r_blank;
    logic          r_overrun;

    logic [6:0]    w_lit;
    logic [CW-1:0] w_count_nxt;
    logic          w_stable;
    logic          w_new_stable;
    logic          w_hs;
    logic          w_lk_hit;
    logic [3:0]    w_lk_nibble;
    logic          w_lk_blank;
    logic          w_accept;
    state_t        w_state_nxt;
    logic          w_valid_nxt;
    logic [3:0]    w_nibble_nxt;
    logic          w_err_nxt;
    logic          w_blank_nxt;
    logic          w_overrun_nxt;
    logic [6:0]    w_acc_nxt;

    assign w_lit = ACTIVE_LOW ? ~r_seg_q : r_seg_q;

    seg7_lookup u_lookup (
        .i_lit    (w_lit),
        .o_hit    (w_lk_hit),
        .o_nibble (w_lk_nibble),
        .o_blank  (w_lk_blank)
    );

    // r_count is (samples of the current seg_q value) - 1, saturating, so the
    // pattern is stable once it has been seen STABLE_CYCLES times in a row.
    always_comb begin
        w_count_nxt = r_count;
        if (seg_i != r_seg_q) begin
            w_count_nxt = '0;
        end else if (r_count != C_CNT_MAX) begin
            w_count_nxt = r_count + CW'(1);
        end
    end

    assign w_stable     = (r_count >= C_CNT_ACC);
    assign w_new_stable = (r_count == C_CNT_ACC);
    assign w_hs         = r_valid && out_ready;

    // LOCK accepts directly when the bus has moved off the locked pattern, so a
    // change seen while locked costs no extra cycle of latency.
    assign w_accept = w_stable &&
                      ((r_state == S_WAIT) ||
                       ((r_state == S_LOCK) && (r_seg_q != r_seg_acc)));

    always_comb begin
        w_state_nxt   = r_state;
        w_valid_nxt   = r_valid;
        w_nibble_nxt  = r_nibble;
        w_err_nxt     = r_err;
        w_blank_nxt   = r_blank;
        w_overrun_nxt = 1'b0;
        w_acc_nxt     = r_seg_acc;
        if (w_accept) begin
            w_acc_nxt = r_seg_q;
            if (w_lk_blank) begin
                w_blank_nxt = 1'b1;
                w_state_nxt = S_LOCK;
            end else begin
                w_blank_nxt  = 1'b0;
                w_valid_nxt  = 1'b1;
                w_nibble_nxt = w_lk_hit ? w_lk_nibble : 4'h0;
                w_err_nxt    = !w_lk_hit;
                w_state_nxt  = S_EMIT;
            end
        end else begin
            case (r_state)
                S_EMIT: begin
                    if (w_hs) begin
                        w_valid_nxt = 1'b0;
                        w_state_nxt = (r_seg_q == r_seg_acc) ? S_LOCK : S_WAIT;
                    end else if (w_new_stable && (r_seg_q != r_seg_acc)) begin
                        w_overrun_nxt = 1'b1;
                    end
                end
                S_LOCK: begin
                    if (r_seg_q != r_seg_acc) begin
                        w_state_nxt = S_WAIT;
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg_q   <= C_SEG_RST;
            r_seg_acc <= C_SEG_RST;
            r_count   <= '0;
            r_state   <= S_WAIT;
            r_valid   <= 1'b0;
            r_nibble  <= 4'h0;
            r_err     <= 1'b0;
            r_blank   <= 1'b1;
            r_overrun <= 1'b0;
        end else begin
            r_seg_q   <= seg_i;
            r_seg_acc <= w_acc_nxt;
            r_count   <= w_count_nxt;
            r_state   <= w_state_nxt;
            r_valid   <= w_valid_nxt;
            r_nibble  <= w_nibble_nxt;
            r_err     <= w_err_nxt;
            r_blank   <= w_blank_nxt;
            r_overrun <= w_overrun_nxt;
        end
    end

    assign out_valid  = r_valid;
    assign out_nibble = r_nibble;
    assign out_err    = r_err;
    assign blank      = r_blank;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_seg7_readback_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_readback_decoder
// Brief    : Scoreboard bench for seg7_readback_decoder against a run-length model.
// Revision : 1.0
// ============================================================================
module tb_seg7_readback_decoder;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] seg_i = 7'h7F;
    logic       out_ready = 1'b1;
    logic       out_valid;
    logic [3:0] out_nibble;
    logic       out_err;
    logic       blank;
    logic       overrun;

    always #5 clk = ~clk;

    seg7_readback_decoder #(
        .STABLE_CYCLES (S),
        .ACTIVE_LOW    (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_i      (seg_i),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_nibble (out_nibble),
        .out_err    (out_err),
        .blank      (blank),
        .overrun    (overrun)
    );

    typedef struct packed {
        logic [3:0] nib;
        logic       err;
    } exp_t;

    logic [6:0] hex_lit [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [6:0] al_pat  [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_xfer  = 0;
    int   n_ovr   = 0;
    bit   mon_en  = 1'b0;

    // Reference model: run length of the sampled bus value, plus whether a
    // fresh stable run may be reported and whether a value is outstanding.
    logic [6:0] m_cur   = 7'h7F;
    int         m_run   = 1;
    bit         m_armed = 1'b1;
    bit         m_pend  = 1'b0;
    bit         m_blank = 1'b1;
    bit         m_ov    = 1'b0;
    logic [6:0] m_held  = 7'h7F;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void decode(input logic [6:0] seg, output bit is_blank, output exp_t e);
        logic [6:0] lit;
        lit      = ~seg;
        is_blank = (lit == 7'h00);
        e.nib    = 4'h0;
        e.err    = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (lit == hex_lit[i]) begin
                e.nib = 4'(i);
                e.err = 1'b0;
            end
        end
    endfunction

    task automatic model_step(input logic [6:0] seg, input bit rdy, input bit r);
        bit   blk;
        exp_t e;
        m_ov = 1'b0;
        if (r) begin
            m_cur   = 7'h7F;
            m_run   = 1;
            m_armed = 1'b1;
            m_pend  = 1'b0;
            m_blank = 1'b1;
            sbq.delete();
            return;
        end
        if (!m_pend && m_armed && m_run >= S) begin
            m_armed = 1'b0;
            decode(m_cur, blk, e);
            if (blk) begin
                m_blank = 1'b1;
            end else begin
                m_blank = 1'b0;
                m_pend  = 1'b1;
                m_held  = m_cur;
                sbq.push_back(e);
            end
        end else if (m_pend && rdy) begin
            m_pend  = 1'b0;
            m_armed = (m_cur != m_held);
        end else if (m_pend && m_run == S && m_cur != m_held) begin
            m_ov = 1'b1;
        end
        if (seg == m_cur) begin
            if (m_run < 1000) m_run++;
        end else begin
            m_cur = seg;
            m_run = 1;
            if (!m_pend) m_armed = 1'b1;
        end
    endtask

    task automatic cyc(input logic [6:0] seg, input bit rdy, input bit r);
        seg_i     = seg;
        out_ready = rdy;
        rst       = r;
        @(posedge clk);
        #1;
        model_step(seg, rdy, r);
        #1;
    endtask

    task automatic hold(input logic [6:0] seg, input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(seg, rdy, 1'b0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("valid", 32'(out_valid), 32'(m_pend));
            chk("blank", 32'(blank), 32'(m_blank));
            chk("overrun", 32'(overrun), 32'(m_ov));
            if (overrun) n_ovr++;
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL scoreboard: got out_valid=1 nibble=%0h required no pending value", out_nibble);
                end else begin
                    chk("nibble", 32'(out_nibble), 32'(sbq[0].nib));
                    chk("err", 32'(out_err), 32'(sbq[0].err));
                    if (out_ready) begin
                        void'(sbq.pop_front());
                        n_xfer++;
                    end
                end
            end
        end
    end

    initial begin
        int x0;
        int o0;
        logic [6:0] pat;

        cyc(7'h7F, 1'b1, 1'b1);
        cyc(7'h7F, 1'b1, 1'b1);
        mon_en = 1'b1;
        chk("reset_nibble", 32'(out_nibble), 32'h0);
        chk("reset_err", 32'(out_err), 32'h0);

        x0 = n_xfer;
        hold(7'h24, 8, 1'b1);
        chk("single_transfer_2", 32'(n_xfer - x0), 32'd1);

        x0 = n_xfer;
        for (int i = 0; i < 16; i++) hold(al_pat[i], 8, 1'b1);
        chk("sweep_transfers", 32'(n_xfer - x0), 32'd16);

        x0 = n_xfer;
        hold(7'h30, 2, 1'b1);
        hold(7'h19, 2, 1'b1);
        hold(7'h30, 8, 1'b1);
        chk("glitch_transfers", 32'(n_xfer - x0), 32'd1);

        x0 = n_xfer;
        hold(7'h55, 8, 1'b1);
        hold(7'h7F, 8, 1'b1);
        chk("err_then_blank_transfers", 32'(n_xfer - x0), 32'd1);
        chk("blank_level", 32'(blank), 32'd1);

        x0 = n_xfer;
        o0 = n_ovr;
        hold(7'h79, 6, 1'b0);
        hold(7'h24, 6, 1'b0);
        chk("overrun_pulses", 32'(n_ovr - o0), 32'd1);
        hold(7'h24, 8, 1'b1);
        chk("overrun_transfers", 32'(n_xfer - x0), 32'd2);

        hold(7'h12, 6, 1'b0);
        cyc(7'h12, 1'b0, 1'b1);
        chk("rst_drops_valid", 32'(out_valid), 32'd0);
        x0 = n_xfer;
        hold(7'h12, 6, 1'b0);
        hold(7'h12, 2, 1'b1);
        chk("rst_reemit", 32'(n_xfer - x0), 32'd1);

        for (int it = 0; it < 250; it++) begin
            case ($urandom_range(0, 3))
                0:       pat = 7'($urandom & 32'h7F);
                1:       pat = 7'h7F;
                default: pat = al_pat[$urandom_range(0, 15)];
            endcase
            if ($urandom_range(0, 39) == 0) begin
                cyc(pat, 1'b0, 1'b1);
            end else begin
                for (int k = 0, n = $urandom_range(1, 9); k < n; k++)
                    cyc(pat, ($urandom_range(0, 3) != 0), 1'b0);
            end
        end

        hold(7'h7F, 12, 1'b1);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
